// File: rtl/i2_class_arbiter.sv
// i2_class_arbiter
//   Packet-locking round-robin write arbiter for one traffic class FIFO of
//   the i2 router. Chooses which of two input ports writes into the class
//   FIFO, steers the input mux and back-pressures the ports.
//
//   Optional feature: define I2_ARB_TIMEOUT_EN to abort a locked packet after
//   TIMEOUT idle cycles of the owning port. Without it, abort is tied to 0
//   and a lock is held indefinitely.
//
// Parameters
//   HEAD     head code this instance opens packets on (000 regular, 001 priority)
//   TIMEOUT  idle cycles in a locked packet before abort (2..255)
//
// Ports
//   clk            clock, rising edge
//   rst            synchronous active-low reset
//   input_req1/2   port 1/2 presents a valid flit
//   head1/2        port 1/2 flit type (data[15:13])
//   FIFO_full      class FIFO full
//   FIFO_wr        FIFO write strobe (combinational)
//   select         input mux select, 0 = port 1, 1 = port 2 (holds when idle)
//   input_bussy1/2 0 only in a cycle where that port's flit is written
//   lock           registered state: 00 IDLE, 01 LOCK1, 10 LOCK2
//   error          registered one-cycle pulse on a head flit inside a packet
//   abort          registered one-cycle pulse on lock timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet open; arbitrate head flits matching HEAD
// LOCK1 | port 1 owns the FIFO until its tail (or error/abort)
// LOCK2 | port 2 owns the FIFO until its tail (or error/abort)

module i2_class_arbiter #(
  parameter logic [2:0] HEAD    = 3'b000,
  parameter int         TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       input_req1,
  input  logic       input_req2,
  input  logic [2:0] head1,
  input  logic [2:0] head2,
  input  logic       FIFO_full,
  output logic       FIFO_wr,
  output logic       select,
  output logic       input_bussy1,
  output logic       input_bussy2,
  output logic [1:0] lock,
  output logic       error,
  output logic       abort
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK1 = 2'b01,
    LOCK2 = 2'b10
  } state_t;

  localparam logic [2:0] TAIL = 3'b011;

  // Elaboration-time guard on the timeout range; also keeps TIMEOUT
  // referenced in builds without the timeout feature.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("i2_class_arbiter: TIMEOUT out of range 2..255");
  end

  state_t state_q, state_d;
  logic   pref_q, pref_d;
  logic   select_q;
  logic   error_q, error_d;
  logic   abort_q, abort_d;
  logic   wr_int;
  logic   sel_now;
  logic   cand1, cand2, grant2;
  logic   own_req;
  logic   [2:0] own_head;
  logic   own_is_head;

`ifdef I2_ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
`endif

  assign cand1 = input_req1 && (head1 == HEAD);
  assign cand2 = input_req2 && (head2 == HEAD);

  // Flit seen from the port that currently owns the lock.
  assign own_req     = (state_q == LOCK2) ? input_req2 : input_req1;
  assign own_head    = (state_q == LOCK2) ? head2 : head1;
  assign own_is_head = (own_head == 3'b000) || (own_head == 3'b001);

  always_comb begin
    state_d = state_q;
    pref_d  = pref_q;
    error_d = 1'b0;
    abort_d = 1'b0;
    wr_int  = 1'b0;
    sel_now = select_q;
    grant2  = 1'b0;
`ifdef I2_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (!FIFO_full && (cand1 || cand2)) begin
          grant2  = cand2 && (!cand1 || pref_q);
          wr_int  = 1'b1;
          sel_now = grant2;
          state_d = grant2 ? LOCK2 : LOCK1;
          pref_d  = !grant2;
`ifdef I2_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      LOCK1, LOCK2: begin
        if (own_req && own_is_head) begin
          // New head inside an open packet: drop the lock, re-arbitrate.
          error_d = 1'b1;
          state_d = IDLE;
        end else if (own_req && !FIFO_full) begin
          wr_int  = 1'b1;
          sel_now = (state_q == LOCK2);
          if (own_head == TAIL) state_d = IDLE;
`ifdef I2_ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
`ifdef I2_ARB_TIMEOUT_EN
        else if (!own_req && !FIFO_full) begin
          if (cnt_q == TO_LAST) begin
            abort_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // No FIFO writes are issued while reset is held.
  assign FIFO_wr      = wr_int && rst;
  assign select       = FIFO_wr ? sel_now : select_q;
  assign input_bussy1 = !(FIFO_wr && !select);
  assign input_bussy2 = !(FIFO_wr && select);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      pref_q   <= 1'b0;
      select_q <= 1'b0;
      error_q  <= 1'b0;
      abort_q  <= 1'b0;
`ifdef I2_ARB_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      pref_q   <= pref_d;
      select_q <= select;
      error_q  <= error_d;
      abort_q  <= abort_d;
`ifdef I2_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign lock  = state_q;
  assign error = error_q;
`ifdef I2_ARB_TIMEOUT_EN
  assign abort = abort_q;
`else
  assign abort = 1'b0;
`endif

endmodule

// File: tb/tb_i2_class_arbiter.sv
// Directed bench for i2_class_arbiter (HEAD=000, TIMEOUT=16).
// Inputs change on the falling edge; outputs are sampled 1 ns later.

module tb_i2_class_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       input_req1, input_req2;
  logic [2:0] head1, head2;
  logic       FIFO_full;
  logic       FIFO_wr, select, input_bussy1, input_bussy2;
  logic [1:0] lock;
  logic       error, abort;

  int n_checks = 0;
  int n_errors = 0;

  i2_class_arbiter #(.HEAD(3'b000), .TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .input_req1   (input_req1),
    .input_req2   (input_req2),
    .head1        (head1),
    .head2        (head2),
    .FIFO_full    (FIFO_full),
    .FIFO_wr      (FIFO_wr),
    .select       (select),
    .input_bussy1 (input_bussy1),
    .input_bussy2 (input_bussy2),
    .lock         (lock),
    .error        (error),
    .abort        (abort)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic r1, input logic [2:0] h1,
                       input logic r2, input logic [2:0] h2, input logic full);
    @(negedge clk);
    rst        = r;
    input_req1 = r1;
    head1      = h1;
    input_req2 = r2;
    head2      = h2;
    FIFO_full  = full;
    #1;
  endtask

  task automatic check_wr(input string tag, input logic wr, input logic sel,
                          input logic b1, input logic b2);
    check({tag, "_wr"}, FIFO_wr, wr);
    check({tag, "_sel"}, select, sel);
    check({tag, "_b1"}, input_bussy1, b1);
    check({tag, "_b2"}, input_bussy2, b2);
  endtask

  initial begin
    rst = 1'b0; input_req1 = 1'b0; input_req2 = 1'b0;
    head1 = 3'b000; head2 = 3'b000; FIFO_full = 1'b0;

    // reset state
    drive(0, 0, 3'b000, 0, 3'b000, 0);
    drive(0, 0, 3'b000, 0, 3'b000, 0);
    check_wr("rst", 0, 0, 1, 1);
    check("rst_lock", lock, 0);
    check("rst_err", error, 0);
    check("rst_abort", abort, 0);
    drive(0, 1, 3'b000, 1, 3'b000, 0);
    check("rst_req_wr", FIFO_wr, 0);

    // simultaneous heads: port 1 first, then port 2 right after the tail
    drive(1, 1, 3'b000, 1, 3'b000, 0);
    check("pair1_lock", lock, 0);
    check_wr("pair1_head", 1, 0, 0, 1);
    drive(1, 1, 3'b010, 1, 3'b000, 0);
    check("pair1_lock1", lock, 1);
    check_wr("pair1_body1", 1, 0, 0, 1);
    drive(1, 1, 3'b010, 1, 3'b000, 0);
    check_wr("pair1_body2", 1, 0, 0, 1);
    drive(1, 1, 3'b011, 1, 3'b000, 0);
    check_wr("pair1_tail", 1, 0, 0, 1);
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check("p2_lock_idle", lock, 0);
    check_wr("p2_head", 1, 1, 1, 0);
    drive(1, 0, 3'b000, 1, 3'b011, 0);
    check("p2_lock2", lock, 2);
    check_wr("p2_tail", 1, 1, 1, 0);
    drive(1, 1, 3'b000, 1, 3'b000, 0);
    check("pair2_lock", lock, 0);
    check_wr("pair2_head", 1, 0, 0, 1);

    // FIFO full for 4 cycles inside LOCK1
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 3'b010, 0, 3'b000, 1);
      check_wr("full_stall", 0, 0, 1, 1);
      check("full_lock", lock, 1);
    end
    drive(1, 1, 3'b010, 0, 3'b000, 0);
    check("full_release_lock", lock, 1);
    check_wr("full_release", 1, 0, 0, 1);
    drive(1, 1, 3'b011, 0, 3'b000, 0);
    check_wr("full_tail", 1, 0, 0, 1);

    // head flit inside LOCK2 -> error, re-arbitrated next cycle
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check("err_lock_idle", lock, 0);
    check_wr("err_head", 1, 1, 1, 0);
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check("err_lock2", lock, 2);
    check_wr("err_viol", 0, 1, 1, 1);
    check("err_pre", error, 0);
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check("err_pulse", error, 1);
    check("err_lock", lock, 0);
    check_wr("err_regrant", 1, 1, 1, 0);
    drive(1, 0, 3'b000, 1, 3'b011, 0);
    check("err_clear", error, 0);
    check("err_relock", lock, 2);
    check_wr("err_tail", 1, 1, 1, 0);

    // non-matching head code is ignored by this instance
    drive(1, 1, 3'b001, 0, 3'b000, 0);
    check("nm_lock", lock, 0);
    check_wr("nm", 0, 1, 1, 1);

    // reset in the middle of LOCK2
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check_wr("mr_head", 1, 1, 1, 0);
    drive(1, 0, 3'b000, 1, 3'b010, 0);
    check("mr_lock2", lock, 2);
    check_wr("mr_body", 1, 1, 1, 0);
    drive(0, 0, 3'b000, 1, 3'b010, 0);
    check("mr_rst_wr", FIFO_wr, 0);
    drive(1, 1, 3'b000, 0, 3'b000, 0);
    check("mr_lock", lock, 0);
    check_wr("mr_p1_head", 1, 0, 0, 1);
    drive(1, 1, 3'b011, 0, 3'b000, 0);
    check("mr_lock1", lock, 1);
    check_wr("mr_p1_tail", 1, 0, 0, 1);

    // port 1 silent after its head while port 2 waits with a head
    drive(1, 1, 3'b000, 0, 3'b000, 0);
    check_wr("to_head", 1, 0, 0, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 3'b000, 1, 3'b000, 0);
      check("to_wait_lock", lock, 1);
      check("to_wait_abort", abort, 0);
      check_wr("to_wait", 0, 0, 1, 1);
    end
`ifdef I2_ARB_TIMEOUT_EN
    drive(1, 0, 3'b000, 1, 3'b000, 0);
    check("to_abort", abort, 1);
    check("to_lock_idle", lock, 0);
    check_wr("to_p2_grant", 1, 1, 1, 0);
    drive(1, 0, 3'b000, 1, 3'b011, 0);
    check("to_abort_clear", abort, 0);
    check("to_lock2", lock, 2);
    check_wr("to_p2_tail", 1, 1, 1, 0);
`else
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 3'b000, 1, 3'b000, 0);
      check("hold_lock", lock, 1);
      check("hold_abort", abort, 0);
      check("hold_wr", FIFO_wr, 0);
    end
    drive(1, 1, 3'b011, 1, 3'b000, 0);
    check("hold_lock_end", lock, 1);
    check_wr("hold_tail", 1, 0, 0, 1);
    drive(1, 0, 3'b000, 0, 3'b000, 0);
    check("hold_idle", lock, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
